// File: rtl/csi_rx_pkg.sv
// Shared types and constants for the CSI-2 receive packet handler.
package csi_rx_pkg;

  localparam logic [5:0] DT_FS = 6'h00;
  localparam logic [5:0] DT_FE = 6'h01;
  localparam logic [5:0] DT_LS = 6'h02;
  localparam logic [5:0] DT_LE = 6'h03;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD
  } state_t;

  typedef struct packed {
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;
    logic [7:0]  ecc;
  } csi_hdr_t;

endpackage

// File: rtl/csi_rx_payload_ctr.sv
// Long-packet byte tracker: remaining-byte count (payload plus CRC), per-word
// byte enables, last-payload-word flag and end-of-packet condition.
module csi_rx_payload_ctr (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic [15:0] load_wc,
  input  logic        advance,
  input  logic [15:0] wc,
  output logic [1:0]  be,
  output logic        last,
  output logic        done
);

  logic [16:0] rem;
  logic [16:0] wc_x;
  logic [16:0] b;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rem <= '0;
    end else if (load) begin
      rem <= {1'b0, load_wc} + 17'd2;
    end else if (advance) begin
      rem <= rem - 17'd2;
    end
  end

  // b is the index of the low byte carried by the current word
  assign wc_x  = {1'b0, wc};
  assign b     = wc_x + 17'd2 - rem;
  assign be[0] = b < wc_x;
  assign be[1] = (b + 17'd1) < wc_x;
  assign last  = (b < wc_x) && ((b + 17'd2) >= wc_x);
  assign done  = rem <= 17'd2;

endmodule

// File: rtl/csi_rx_packet_handler.sv
// CSI-2 packet layer parser: header decode, short-packet sync pulses and
// long-packet payload streaming with byte enables.
module csi_rx_packet_handler #(
  parameter logic [15:0] MAX_WC      = 16'd8192,
  parameter logic [5:0]  LONG_DT_MIN = 6'h10
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] word_data,
  input  logic        word_valid,
  output logic        wait_for_sync,
  output logic        packet_done,
  output logic        frame_start,
  output logic        frame_end,
  output logic        line_start,
  output logic        line_end,
  output logic [1:0]  vc,
  output logic [5:0]  data_type,
  output logic [15:0] word_count,
  output logic [7:0]  ecc,
  output logic [15:0] payload_data,
  output logic [1:0]  payload_be,
  output logic        payload_valid,
  output logic        payload_last,
  output logic        err_length,
  output logic        err_truncated
);
  import csi_rx_pkg::*;

  state_t   state, state_nxt;
  csi_hdr_t hdr, hdr_new;
  logic [15:0] word0;
  logic        hdr_load, ctr_load, ctr_adv;
  logic [1:0]  ctr_be;
  logic        ctr_last, ctr_done;
  logic        done_n, fs_n, fe_n, ls_n, le_n, pv_n, last_n, el_n, et_n;
  logic [1:0]  be_n;

  csi_rx_payload_ctr u_ctr (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (ctr_load & enable),
    .load_wc (hdr_new.wc),
    .advance (ctr_adv & enable),
    .wc      (hdr.wc),
    .be      (ctr_be),
    .last    (ctr_last),
    .done    (ctr_done)
  );

  always_comb begin
    state_nxt = state;
    hdr_load  = 1'b0;
    ctr_load  = 1'b0;
    ctr_adv   = 1'b0;
    done_n    = 1'b0;
    fs_n      = 1'b0;
    fe_n      = 1'b0;
    ls_n      = 1'b0;
    le_n      = 1'b0;
    pv_n      = 1'b0;
    be_n      = 2'b00;
    last_n    = 1'b0;
    el_n      = 1'b0;
    et_n      = 1'b0;
    // word0 = {WC[7:0], DI}, current word = {ECC, WC[15:8]}
    hdr_new   = {word0[7:6], word0[5:0], word_data[7:0], word0[15:8], word_data[15:8]};
    case (state)
      IDLE: begin
        if (word_valid) state_nxt = HDR;
      end
      HDR: begin
        if (!word_valid) begin
          et_n      = 1'b1;
          done_n    = 1'b1;
          state_nxt = IDLE;
        end else begin
          hdr_load = 1'b1;
          if (hdr_new.dt < LONG_DT_MIN) begin
            fs_n      = hdr_new.dt == DT_FS;
            fe_n      = hdr_new.dt == DT_FE;
            ls_n      = hdr_new.dt == DT_LS;
            le_n      = hdr_new.dt == DT_LE;
            done_n    = 1'b1;
            state_nxt = IDLE;
          end else if (hdr_new.wc > MAX_WC) begin
            el_n      = 1'b1;
            done_n    = 1'b1;
            state_nxt = IDLE;
          end else begin
            ctr_load  = 1'b1;
            state_nxt = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (!word_valid) begin
          et_n      = 1'b1;
          done_n    = 1'b1;
          state_nxt = IDLE;
        end else begin
          ctr_adv = 1'b1;
          be_n    = ctr_be;
          pv_n    = |ctr_be;
          last_n  = ctr_last;
          if (ctr_done) begin
            done_n    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= IDLE;
      word0         <= '0;
      hdr           <= '0;
      payload_data  <= '0;
      packet_done   <= 1'b0;
      frame_start   <= 1'b0;
      frame_end     <= 1'b0;
      line_start    <= 1'b0;
      line_end      <= 1'b0;
      payload_valid <= 1'b0;
      payload_be    <= 2'b00;
      payload_last  <= 1'b0;
      err_length    <= 1'b0;
      err_truncated <= 1'b0;
    end else if (!enable) begin
      // header fields deliberately hold across a disable
      state         <= IDLE;
      payload_data  <= '0;
      packet_done   <= 1'b0;
      frame_start   <= 1'b0;
      frame_end     <= 1'b0;
      line_start    <= 1'b0;
      line_end      <= 1'b0;
      payload_valid <= 1'b0;
      payload_be    <= 2'b00;
      payload_last  <= 1'b0;
      err_length    <= 1'b0;
      err_truncated <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && word_valid) word0 <= word_data;
      if (hdr_load) hdr <= hdr_new;
      if (ctr_adv) payload_data <= word_data;
      packet_done   <= done_n;
      frame_start   <= fs_n;
      frame_end     <= fe_n;
      line_start    <= ls_n;
      line_end      <= le_n;
      payload_valid <= pv_n;
      payload_be    <= be_n;
      payload_last  <= last_n;
      err_length    <= el_n;
      err_truncated <= et_n;
    end
  end

  assign wait_for_sync = state == IDLE;
  assign vc            = hdr.vc;
  assign data_type     = hdr.dt;
  assign word_count    = hdr.wc;
  assign ecc           = hdr.ecc;

endmodule

// File: tb/tb_csi_rx_packet_handler.sv
// Randomised packet-stream bench for csi_rx_packet_handler with a byte-level
// reference model of the CSI-2 packet layer.
module tb_csi_rx_packet_handler;

  logic        clock = 1'b0;
  logic        reset_n, enable, word_valid;
  logic [15:0] word_data;
  logic        wait_for_sync, packet_done, frame_start, frame_end, line_start, line_end;
  logic [1:0]  vc;
  logic [5:0]  data_type;
  logic [15:0] word_count;
  logic [7:0]  ecc;
  logic [15:0] payload_data;
  logic [1:0]  payload_be;
  logic        payload_valid, payload_last, err_length, err_truncated;

  int tests = 0;
  int fails = 0;
  logic [31:0] hdr_exp;

  always #5 clock = ~clock;

  csi_rx_packet_handler dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .enable        (enable),
    .word_data     (word_data),
    .word_valid    (word_valid),
    .wait_for_sync (wait_for_sync),
    .packet_done   (packet_done),
    .frame_start   (frame_start),
    .frame_end     (frame_end),
    .line_start    (line_start),
    .line_end      (line_end),
    .vc            (vc),
    .data_type     (data_type),
    .word_count    (word_count),
    .ecc           (ecc),
    .payload_data  (payload_data),
    .payload_be    (payload_be),
    .payload_valid (payload_valid),
    .payload_last  (payload_last),
    .err_length    (err_length),
    .err_truncated (err_truncated)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] status();
    return {20'd0, wait_for_sync, packet_done, frame_start, frame_end, line_start, line_end,
            payload_valid, payload_be, payload_last, err_length, err_truncated};
  endfunction

  function automatic logic [31:0] mk(input logic wfs, input logic done, input logic fs,
                                     input logic fe, input logic ls, input logic le,
                                     input logic pv, input logic [1:0] be, input logic last,
                                     input logic el, input logic et);
    return {20'd0, wfs, done, fs, fe, ls, le, pv, be, last, el, et};
  endfunction

  function automatic logic [31:0] hdr_now();
    return {vc, data_type, word_count, ecc};
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      word_valid = 1'b0;
      word_data  = 16'($urandom);
      step();
      check_eq("idle", status(), mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
    end
  endtask

  // mode: 0 complete, 1 drop word_valid, 2 reset pulse, 3 enable low -- at word abort_k
  task automatic send_packet(input logic [1:0] pvc, input logic [5:0] pdt, input logic [15:0] pwc,
                             input int mode, input int abort_k);
    logic [7:0]  pkt_ecc;
    logic [7:0]  bytes[$];
    logic [15:0] w[$];
    logic [31:0] hdr_pkt;
    bit is_long, too_long;
    int nwords, ak;
    pkt_ecc  = 8'($urandom);
    is_long  = pdt >= 6'h10;
    too_long = is_long && (pwc > 16'd8192);
    w.push_back({pwc[7:0], pvc, pdt});
    w.push_back({pkt_ecc, pwc[15:8]});
    if (is_long && !too_long) begin
      for (int i = 0; i < int'(pwc) + 2; i++) bytes.push_back(8'($urandom));
      if (pwc[0]) bytes.push_back(8'($urandom));
      for (int i = 0; i < bytes.size(); i += 2) w.push_back({bytes[i+1], bytes[i]});
    end
    nwords  = w.size();
    hdr_pkt = {pvc, pdt, pwc, pkt_ecc};
    ak = (abort_k >= nwords) ? nwords - 1 : ((abort_k < 1) ? 1 : abort_k);
    for (int k = 0; k < nwords; k++) begin
      logic [31:0] want;
      logic [1:0]  be;
      logic [15:0] m;
      bit last, done;
      int j;
      if (mode != 0 && k == ak) begin
        if (mode == 1) begin
          word_valid = 1'b0;
          word_data  = 16'($urandom);
        end else begin
          word_valid = 1'b1;
          word_data  = w[k];
          if (mode == 2) begin
            reset_n = 1'b0;
            hdr_exp = '0;
          end else begin
            enable = 1'b0;
          end
        end
        step();
        reset_n = 1'b1;
        enable  = 1'b1;
        check_eq("abort_status", status(),
                 mk(1, mode == 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, mode == 1));
        check_eq("abort_header", hdr_now(), hdr_exp);
        if (mode != 1) check_eq("abort_data", 32'(payload_data), 32'd0);
        return;
      end
      word_valid = 1'b1;
      word_data  = w[k];
      step();
      if (k == 0) begin
        want = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
      end else if (k == 1) begin
        hdr_exp = hdr_pkt;
        check_eq("header", hdr_now(), hdr_exp);
        if (!is_long)
          want = mk(1, 1, pdt == 6'h00, pdt == 6'h01, pdt == 6'h02, pdt == 6'h03, 0, 2'b00, 0, 0, 0);
        else if (too_long)
          want = mk(1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0);
        else
          want = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
      end else begin
        j    = k - 2;
        be   = {(2*j + 1) < int'(pwc), (2*j) < int'(pwc)};
        last = (pwc != 16'd0) && ((int'(pwc) - 1) / 2 == j);
        done = (k == nwords - 1);
        want = mk(done, done, 0, 0, 0, 0, |be, be, last, 0, 0);
        if (|be) begin
          m = {{8{be[1]}}, {8{be[0]}}};
          check_eq("payload_data", 32'(payload_data & m), 32'(w[k] & m));
        end
      end
      check_eq("status", status(), want);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    enable     = 1'b1;
    word_valid = 1'b0;
    word_data  = 16'h0;
    hdr_exp    = '0;
    step();
    step();
    check_eq("reset_status", status(), mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
    check_eq("reset_header", hdr_now(), 32'd0);
    check_eq("reset_data", 32'(payload_data), 32'd0);
    reset_n = 1'b1;
    idle_cycles(2);

    send_packet(2'd0, 6'h00, 16'd1, 0, 0);
    send_packet(2'd0, 6'h2B, 16'd6, 0, 0);
    send_packet(2'd1, 6'h2B, 16'd5, 0, 0);
    send_packet(2'd2, 6'h2C, 16'h4000, 0, 0);
    send_packet(2'd0, 6'h2B, 16'd20, 1, 4);
    send_packet(2'd0, 6'h01, 16'd0, 0, 0);
    send_packet(2'd3, 6'h2A, 16'd10, 2, 3);
    send_packet(2'd1, 6'h02, 16'd5, 0, 0);
    send_packet(2'd1, 6'h03, 16'd7, 0, 0);
    send_packet(2'd2, 6'h2B, 16'd8, 3, 3);
    send_packet(2'd0, 6'h12, 16'd0, 0, 0);
    send_packet(2'd3, 6'h24, 16'd8192, 0, 0);
    send_packet(2'd3, 6'h24, 16'd8193, 0, 0);
    send_packet(2'd0, 6'h08, 16'hBEEF, 0, 0);
    idle_cycles(1);

    for (int n = 0; n < 80; n++) begin
      logic [5:0]  dt;
      logic [15:0] wc;
      int mode;
      if ($urandom_range(0, 1) == 0) begin
        dt = 6'($urandom_range(0, 15));
        wc = 16'($urandom);
      end else begin
        dt = 6'($urandom_range(16, 63));
        wc = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(8193, 65535))
                                         : 16'($urandom_range(0, 24));
      end
      mode = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
      send_packet(2'($urandom), dt, wc, mode, $urandom_range(1, 14));
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/csi_rx_packet_handler.md
Name: csi_rx_packet_handler

Overview:
- Consumes aligned 16-bit words from the 2-lane CSI-2 link (word_data/word_valid, byte_clock domain) and parses the CSI-2 packet layer.
- Decodes packet headers, emits short-packet sync events, and streams long-packet payload with byte enables.
- Generates the wait_for_sync and packet_done feedback that re-arms the byte and word aligners for the next SoT.
- Word format: bits [7:0] are lane 0 (earlier byte), bits [15:8] are lane 1.

Parameters:
- MAX_WC, 16'd8192: largest accepted long-packet word count in bytes; a larger WC is a length error.
- LONG_DT_MIN, 6'h10: data types at or above this value are long packets.

Ports:
- clock  in  1  byte clock from the link layer
- reset_n  in  1  synchronous, active-low reset
- enable  in  1  active-high enable; low forces IDLE
- word_data  in  16  aligned word from word aligner
- word_valid  in  1  word_data is synced and aligned
- wait_for_sync  out  1  high while awaiting a packet header
- packet_done  out  1  one-cycle pulse: packet finished or aborted
- frame_start, frame_end, line_start, line_end  out  1 each  one-cycle short-packet pulses
- vc  out  2  virtual channel of last header
- data_type  out  6  data type of last header
- word_count  out  16  WC/short-packet data field of last header
- ecc  out  8  ECC byte of last header; not checked
- payload_data  out  16  payload bytes
- payload_be  out  2  byte enables for payload_data
- payload_valid  out  1  payload_data/payload_be valid
- payload_last  out  1  final payload word of the packet
- err_length  out  1  pulse: long WC > MAX_WC, packet dropped
- err_truncated  out  1  pulse: word_valid fell mid-packet

Behaviour:
- Reset (reset_n=0 at a clock edge): state IDLE; wait_for_sync=1; all pulses, payload_valid, payload_be and errors 0; vc, data_type, word_count, ecc and payload_data all 0.
- enable=0: same as reset, except header fields hold their values.
- FSM states:
  - IDLE: wait_for_sync=1. On word_valid, latch word0 as {WC[7:0], DI}; go HDR.
  - HDR, word_valid=1: latch word1 as {ECC, WC[15:8]}. Register vc=DI[7:6], dt=DI[5:0], word_count and ecc.
    - Short packet (dt < LONG_DT_MIN): pulse frame_start/frame_end/line_start/line_end for dt 0x00/0x01/0x02/0x03; other short types produce no pulse. Pulse packet_done; go IDLE.
    - Long packet, WC > MAX_WC: pulse err_length and packet_done; go IDLE.
    - Otherwise: load rem = WC+2 (17-bit; includes the CRC); go PAYLOAD.
  - PAYLOAD: each valid word covers byte indices b and b+1, where b = WC+2-rem.
    - payload_be[i] = 1 when (b+i) < WC. payload_valid = |be.
    - payload_last asserts on the word holding byte WC-1.
    - rem -= 2. When rem ≤ 2 before the decrement: pulse packet_done and go IDLE.
  - The CRC bytes (the last two positions) are never presented as payload. They are not checked.
  - Padding byte when WC is odd: the low byte of the final word is CRC[15:8], and the high byte is discarded.
- Latency: all outputs are registered, 1 cycle after the accepting word. Pulses, payload outputs and the return of wait_for_sync to 1 all land on the same cycle.
- WC=0 long packet: no payload_valid; the single CRC word ends the packet.
- word_valid=0 in HDR or PAYLOAD: next cycle pulse err_truncated and packet_done; go IDLE. Any partial payload already emitted stands, and payload_last is not generated.
- word_valid=0 in IDLE: no action.
- Back-to-back: a header word arriving in the cycle after packet_done is accepted, since the IDLE check uses the current state.
- reset_n low mid-packet: immediate IDLE; no packet_done pulse.

Decomposition:
- Package csi_rx_pkg holds:
  - data-type constants DT_FS=6'h00, DT_FE=6'h01, DT_LS=6'h02, DT_LE=6'h03;
  - state enum {IDLE, HDR, PAYLOAD};
  - packed struct csi_hdr_t {vc, dt, wc, ecc}.
- One sub-module, csi_rx_payload_ctr: owns rem, the byte-enable/last generation, and the done condition.

Test Plan:
- FS short packet: words 16'h0100, 16'hXX00 (DI=0x00, WC=1) -> frame_start=1 and packet_done=1 one cycle after the 2nd word; vc=0; wait_for_sync back to 1.
- RAW10 long packet: DI=0x2B, WC=6, then 4 more words -> 3 payload words with be=2'b11, payload_last on the 3rd, packet_done the cycle after the 4th (CRC) word.
- Odd WC=5: DI=0x2B, 4 more words -> payload be sequence 11, 11, 01; last word (CRC hi + pad) not presented; packet_done once.
- WC=16'h4000 > MAX_WC -> err_length=1 and packet_done=1 after the header; no payload_valid.
- word_valid dropped after 2 of 10 payload words -> err_truncated=1 and packet_done=1 next cycle; IDLE; the next FE packet decodes correctly.
- reset_n=0 mid-payload, then an LS packet -> no packet_done from the aborted packet; line_start=1 for the new one.
